// File: rtl/gcd_result_demux.sv
// 1:2 stream demultiplexer for GCD results: each channel has a 2-entry
// head/tail buffer with valid/ready and a wrapping accepted-word counter.
module gcd_result_demux #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    occ_e             occ_q  [2];
    occ_e             occ_d  [2];
    logic [WIDTH-1:0] head_q [2];
    logic [WIDTH-1:0] head_d [2];
    logic [WIDTH-1:0] tail_q [2];
    logic [WIDTH-1:0] tail_d [2];
    logic [CNT_W-1:0] cnt_q  [2];
    logic [CNT_W-1:0] cnt_d  [2];
    logic [1:0]       valid_q;
    logic [1:0]       valid_d;
    logic [1:0]       push;
    logic [1:0]       pop;

    // Ready looks only at registered occupancy, never at the consumers' ready.
    assign in_ready = (occ_q[in_sel] != FULL);

    assign push = {in_valid & in_ready & in_sel, in_valid & in_ready & ~in_sel};
    assign pop  = {out1_ready & valid_q[1], out0_ready & valid_q[0]};

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
            occ_d[c]  = occ_q[c];
            head_d[c] = head_q[c];
            tail_d[c] = tail_q[c];
            cnt_d[c]  = cnt_q[c] + CNT_W'(push[c]);
            case (occ_q[c])
                EMPTY: begin
                    if (push[c]) begin
                        head_d[c] = in_data;
                        occ_d[c]  = ONE;
                    end
                end
                ONE: begin
                    if (push[c] && pop[c]) begin
                        head_d[c] = in_data;
                    end else if (push[c]) begin
                        tail_d[c] = in_data;
                        occ_d[c]  = FULL;
                    end else if (pop[c]) begin
                        occ_d[c]  = EMPTY;
                    end
                end
                FULL: begin
                    if (pop[c]) begin
                        head_d[c] = tail_q[c];
                        occ_d[c]  = ONE;
                    end
                end
                default: occ_d[c] = EMPTY;
            endcase
            valid_d[c] = (occ_d[c] != EMPTY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data registers are reset too, because the head drives outN_data, which must read 0 after reset.
            for (int c = 0; c < 2; c++) begin
                occ_q[c]  <= EMPTY;
                head_q[c] <= '0;
                tail_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
            valid_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            for (int c = 0; c < 2; c++) begin
                occ_q[c]  <= occ_d[c];
                head_q[c] <= head_d[c];
                tail_q[c] <= tail_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
            valid_q <= valid_d;
        end
    end

    assign out0_data  = head_q[0];
    assign out1_data  = head_q[1];
    assign out0_valid = valid_q[0];
    assign out1_valid = valid_q[1];
    assign cnt0       = cnt_q[0];
    assign cnt1       = cnt_q[1];

endmodule

// File: doc/gcd_result_demux.md
Name: gcd_result_demux

Overview:
- 1:2 stream demultiplexer that routes 16-bit GCD results to one of two consumer channels, selected per word. It is the inverse of the datapath's 2:1 operand mux.
- Sits at the output of the GCD datapath. Each destination channel has its own 2-entry buffer with valid/ready handshake, so one stalled consumer never corrupts the other channel's data.
- Keeps a per-channel count of accepted words for debug and verification.

Parameters:
- WIDTH, 16, data width of input and both outputs.
- CNT_W, 8, width of per-channel accepted-word counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  result word from the GCD datapath.
- in_sel  input  1  destination: 0 routes to channel 0, 1 routes to channel 1.
- in_valid  input  1  in_data/in_sel valid this cycle.
- in_ready  output  1  demux can accept the word for the currently selected channel.
- out0_data  output  WIDTH  channel 0 head word.
- out0_valid  output  1  channel 0 buffer non-empty.
- out0_ready  input  1  channel 0 consumer accepts.
- out1_data  output  WIDTH  channel 1 head word.
- out1_valid  output  1  channel 1 buffer non-empty.
- out1_ready  input  1  channel 1 consumer accepts.
- cnt0  output  CNT_W  words accepted into channel 0.
- cnt1  output  CNT_W  words accepted into channel 1.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Both buffers emptied; occupancy = 0 per channel.
  - out0_valid = out1_valid = 0.
  - out0_data = out1_data = 0.
  - cnt0 = cnt1 = 0.
  - Reset asserted mid-operation discards all buffered words immediately. No word is emitted after release until a new input is accepted.
- Per-channel buffer:
  - 2-entry FIFO with head register (H) and tail register (T).
  - Occupancy state per channel: EMPTY (0), ONE (1), FULL (2).
- in_ready:
  - Combinational: in_ready = (occupancy of channel in_sel != FULL).
  - Depends only on in_sel and registered occupancy. It must not depend on outN_ready (no combinational ready path through the block).
- Push: in_valid & in_ready on a rising edge writes in_data into channel in_sel.
  - EMPTY: write goes to H.
  - ONE with no pop: write goes to T.
  - ONE with simultaneous pop: write goes to H.
- Pop: outN_valid & outN_ready.
  - FULL: T moves to H.
  - ONE: channel goes EMPTY.
- State transitions (per channel; push = accepted word for this channel):
  - EMPTY + push -> ONE.
  - ONE + push, no pop -> FULL.
  - ONE + push + pop -> ONE, new word in H.
  - ONE + pop, no push -> EMPTY.
  - FULL + pop -> ONE. No push is possible in FULL, because in_ready=0 for that channel.
  - FULL, no pop -> FULL.
- Outputs:
  - outN_valid = (occupancy != EMPTY); outN_data = H. Both are registered outputs.
  - Latency: a word accepted at edge k is visible on outN_valid/outN_data after edge k, i.e. in cycle k+1.
  - outN_data holds its last value when the channel is empty. It is don't-care to consumers but must be deterministic.
- Channel independence:
  - A push to channel A and a pop from channel B in the same cycle both take effect.
  - Channel B full does not block pushes to channel A.
- Ordering: words within one channel leave in acceptance order. There is no ordering relation across channels.
- Counters:
  - cntN increments by 1 on each accepted push to channel N.
  - Modulo 2^CNT_W: 255 -> 0 at the default width, no saturation or flag.
- in_valid=0: in_sel and in_data are ignored and no state changes from the input side.

Test Plan:
- Reset then single push: in_data=16'h0015, in_sel=0, in_valid=1 for one cycle, out0_ready=1 -> out0_valid=1 with out0_data=0015 exactly one cycle later for one cycle; out1_valid stays 0; cnt0=1, cnt1=0.
- Backpressure fill channel 1: out1_ready=0, push 0x0003, 0x0007, then attempt 0x0009 on channel 1 -> in_ready=0 on the third; out1_data=0003. Raise out1_ready -> 0003, 0007 emitted in order, then 0009 is accepted when in_ready rises; cnt1=3.
- Isolation: channel 1 FULL and stalled; push 0x0021 to channel 0 -> in_ready=1, out0_data=0021 next cycle; channel 1 contents unchanged.
- Simultaneous push+pop at ONE: channel 0 holds 0x0005 with out0_ready=1, push 0x0006 same cycle -> next cycle out0_data=0006, occupancy ONE, no word lost or duplicated.
- Counter wrap: 256 accepted pushes to channel 0 -> cnt0 goes 255 -> 0; cnt1 unchanged.
- Reset mid-operation: both channels FULL, assert rst_n=0 between edges -> out0_valid and out1_valid drop immediately and counters read 0. After release, the first output word is the first new push.
